fpu_op_dispatch: RTL and testbench
==================================

# fpu_op_dispatch

Parametrised operand dispatcher between the FPU front end and its functional units (addsub, mul, divsqrt, plus any added later). It accepts one recoded operand pair per handshake and registers it. It presents the pair only to the selected unit, with all other units' operands forced to zero. It then returns unit results to the front end in strict issue order through an in-order tag queue, so units with different latencies never reorder the result stream.

## Interface
Parameters:
- DATA_WIDTH, 16, format width; operands and results are DATA_WIDTH+1 bits (recoded).
- NUM_UNITS, 3, number of functional units; unit 0 = addsub, 1 = mul, 2 = divsqrt.
- ORDER_DEPTH, 4, maximum outstanding operations (tag queue depth, power of two, ≥2).
- SEL_WIDTH, $clog2(NUM_UNITS) (minimum 1), derived width of the select field.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_sel  in  SEL_WIDTH  target unit index.
- in_op1, in_op2  in  DATA_WIDTH+1  operands.
- unit_valid  out  NUM_UNITS  per-unit issue valid.
- unit_ready  in  NUM_UNITS  per-unit issue ready.
- unit_op1, unit_op2  out  NUM_UNITS*(DATA_WIDTH+1)  flattened; unit k occupies slice k.
- res_valid  in  NUM_UNITS  per-unit result valid.
- res_data  in  NUM_UNITS*(DATA_WIDTH+1)  flattened unit results.
- res_ready  out  NUM_UNITS  per-unit result pop.
- out_valid  out  1  ordered result valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_WIDTH+1  ordered result.
- out_sel  out  SEL_WIDTH  unit that produced out_data.
- out_err  out  1  entry was an invalid select (in_sel ≥ NUM_UNITS).

## Operation
- Issue register: one entry holding {sel, op1, op2}, plus an issue_valid flag.
- in_ready = !issue_valid | issue_fire. Accepting a request loads the register.
- issue_fire = issue_valid & (count < ORDER_DEPTH) & (sel ≥ NUM_UNITS | unit_ready[sel]).
- unit_valid[k] = issue_valid & (sel == k) & (count < ORDER_DEPTH).
- unit_op1/unit_op2 slice k carries the registered operands only when unit_valid[k]. Otherwise it is all zeros.
- On issue_fire, {sel, err = (sel ≥ NUM_UNITS)} is pushed into the tag queue. Invalid-select entries never reach any unit.
- Tag queue is a circular buffer with read/write pointers and a count from 0 to ORDER_DEPTH. Pointers wrap modulo ORDER_DEPTH.
- Output stage, with queue head h and count > 0:
  - If h.err: out_valid = 1, out_data = 0, out_err = 1.
  - Otherwise: out_valid = res_valid[h.sel], out_data = slice h.sel of res_data, out_err = 0.
  - out_sel = h.sel.
- res_ready[k] = (count > 0) & !h.err & (h.sel == k) & out_ready. All other res_ready bits are 0.
- Pop the queue when out_valid & out_ready.
- Push and pop in the same cycle: count is unchanged. Issue is still blocked if count == ORDER_DEPTH at the start of the cycle; a same-cycle pop does not free a slot for that cycle.
- Each unit returns its own results in order. Results from non-head units wait, held by res_ready = 0.
- When out_valid = 0, out_data = 0, out_sel = 0 and out_err = 0.

## Timing
- Reset state: issue_valid = 0, count = 0, pointers = 0.
- Outputs during and after reset: unit_valid = 0, unit_op* = 0, in_ready = 1, out_valid = 0, out_data = 0, res_ready = 0.
- Reset asserted mid-operation discards the issue entry and all outstanding tags. Unit results that arrive later are not popped (res_ready = 0) until new tags exist; units are reset in parallel.
- Acceptance to unit_valid: 1 cycle. Sustained throughput is 1 operation per cycle while the target unit is ready and count < ORDER_DEPTH.
- Invalid select: accepted at cycle t, pushed at t+1, out_valid with out_err = 1 at t+1 if it is at the queue head.
- res_valid to out_valid is combinational (0 cycles). in_ready depends combinationally on unit_ready and count.
- Held issue: while unit_valid[k] = 1 and unit_ready[k] = 0, operands and sel stay stable.

## Test plan
- Single op: reset, then in_sel = 1, op1 = 0x0A3C, op2 = 0x0455 → next cycle unit_valid = 3'b010, unit_op slice 1 carries the operands, slices 0 and 2 are zero. Unit 1 returns 0x1234 → out_valid, out_data = 0x1234, out_sel = 1.
- Reordering: issue div (sel 2) then add (sel 0). The add result arrives 3 cycles before the div result → add result is held (res_ready[0] = 0) until the div result is output. Output order is div, then add.
- Backpressure: unit_ready[0] = 0 for 5 cycles with two requests → first request held stable in slices, in_ready = 0 for the second. Once unit_ready[0] rises, both issue on consecutive cycles.
- Queue full: 4 ops issued, no results, out_ready = 1 → unit_valid = 0 for the 5th op. Then one result is popped → 5th op issues the following cycle. Count never exceeds 4.
- Invalid select: in_sel = 3 with NUM_UNITS = 3 → no unit_valid; out_valid with out_err = 1 and out_data = 0, in order behind earlier ops.
- Reset mid-flight: 3 ops outstanding, then assert reset for 1 cycle → count = 0, out_valid = 0, in_ready = 1; a new op completes normally.

Source files
------------

// File: rtl/fpu_op_dispatch.sv
// Operand dispatcher: registers one op, issues to the selected unit 1 cycle after acceptance, returns results in issue order.
// Backpressure: holds the issue entry while the unit is busy or the tag queue is full; non-head unit results wait (res_ready = 0).
module fpu_op_dispatch #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_UNITS   = 3,
  parameter int ORDER_DEPTH = 4,
  parameter int SEL_WIDTH   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SEL_WIDTH-1:0]                in_sel,
  input  logic [DATA_WIDTH:0]                 in_op1,
  input  logic [DATA_WIDTH:0]                 in_op2,
  output logic [NUM_UNITS-1:0]                unit_valid,
  input  logic [NUM_UNITS-1:0]                unit_ready,
  output logic [NUM_UNITS*(DATA_WIDTH+1)-1:0] unit_op1,
  output logic [NUM_UNITS*(DATA_WIDTH+1)-1:0] unit_op2,
  input  logic [NUM_UNITS-1:0]                res_valid,
  input  logic [NUM_UNITS*(DATA_WIDTH+1)-1:0] res_data,
  output logic [NUM_UNITS-1:0]                res_ready,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH:0]                 out_data,
  output logic [SEL_WIDTH-1:0]                out_sel,
  output logic                                out_err
);
  localparam int W  = DATA_WIDTH + 1;
  localparam int PW = $clog2(ORDER_DEPTH);

  logic                 issue_valid;
  logic [SEL_WIDTH-1:0] issue_sel;
  logic [W-1:0]         issue_op1;
  logic [W-1:0]         issue_op2;

  logic [SEL_WIDTH-1:0] tag_sel [ORDER_DEPTH];
  logic                 tag_err [ORDER_DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [PW:0]          count;

  logic                 not_full;
  logic                 sel_bad;
  logic                 sel_rdy;
  logic                 issue_fire;
  logic                 has_head;
  logic [SEL_WIDTH-1:0] head_sel;
  logic                 head_err;
  logic                 pop;

  assign not_full   = count < (PW+1)'(ORDER_DEPTH);
  assign sel_bad    = 32'(issue_sel) >= NUM_UNITS;
  assign issue_fire = issue_valid & not_full & (sel_bad | sel_rdy);
  assign in_ready   = !issue_valid | issue_fire;

  assign has_head = count != '0;
  assign head_sel = tag_sel[rd_ptr];
  assign head_err = tag_err[rd_ptr];
  assign pop      = out_valid & out_ready;

  // Only the selected unit sees operands; every other slice is forced to zero.
  always_comb begin
    sel_rdy    = 1'b0;
    unit_valid = '0;
    unit_op1   = '0;
    unit_op2   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (issue_sel == SEL_WIDTH'(k)) begin
        sel_rdy = unit_ready[k];
        if (issue_valid && not_full) begin
          unit_valid[k]      = 1'b1;
          unit_op1[k*W +: W] = issue_op1;
          unit_op2[k*W +: W] = issue_op2;
        end
      end
    end
  end

  // Error entries complete on their own; otherwise the head unit's result is passed straight through.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_sel   = '0;
    out_err   = 1'b0;
    res_ready = '0;
    if (has_head) begin
      if (head_err) begin
        out_valid = 1'b1;
        out_err   = 1'b1;
        out_sel   = head_sel;
      end else begin
        for (int k = 0; k < NUM_UNITS; k++) begin
          if (head_sel == SEL_WIDTH'(k)) begin
            res_ready[k] = out_ready;
            if (res_valid[k]) begin
              out_valid = 1'b1;
              out_data  = res_data[k*W +: W];
              out_sel   = head_sel;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_valid <= 1'b0;
      issue_sel   <= '0;
      issue_op1   <= '0;
      issue_op2   <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      if (in_valid && in_ready) begin
        issue_valid <= 1'b1;
        issue_sel   <= in_sel;
        issue_op1   <= in_op1;
        issue_op2   <= in_op2;
      end else if (issue_fire) begin
        issue_valid <= 1'b0;
      end

      if (issue_fire) begin
        tag_sel[wr_ptr] <= issue_sel;
        tag_err[wr_ptr] <= sel_bad;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      if (issue_fire && !pop) begin
        count <= count + (PW+1)'(1);
      end else if (!issue_fire && pop) begin
        count <= count - (PW+1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_fpu_op_dispatch.sv
// Bench for fpu_op_dispatch: behavioural units, scoreboard of ordered results, vector table plus corner sequences.
module tb_fpu_op_dispatch;
  localparam int DW = 16;
  localparam int NU = 3;
  localparam int OD = 4;
  localparam int SW = 2;
  localparam int W  = DW + 1;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   in_sel;
  logic [W-1:0]    in_op1, in_op2;
  logic [NU-1:0]   unit_valid, unit_ready;
  logic [NU*W-1:0] unit_op1, unit_op2;
  logic [NU-1:0]   res_valid, res_ready;
  logic [NU*W-1:0] res_data;
  logic            out_valid, out_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_err;

  fpu_op_dispatch #(.DATA_WIDTH(DW), .NUM_UNITS(NU), .ORDER_DEPTH(OD)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_op1(in_op1), .in_op2(in_op2),
    .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_op1(unit_op1), .unit_op2(unit_op2),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel), .out_err(out_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural units: each returns op1 + op2 + unit index, in its own issue order.
  logic [W-1:0]  ures [NU][16];
  int            uwr [NU];
  int            urd [NU];
  logic [NU-1:0] res_en;

  always @(posedge clock) begin
    for (int k = 0; k < NU; k++) begin
      if (reset) begin
        uwr[k] <= 0;
        urd[k] <= 0;
      end else begin
        if (unit_valid[k] && unit_ready[k]) begin
          ures[k][uwr[k] % 16] <= unit_op1[k*W +: W] + unit_op2[k*W +: W] + W'(k);
          uwr[k] <= uwr[k] + 1;
        end
        if (res_valid[k] && res_ready[k]) urd[k] <= urd[k] + 1;
      end
    end
  end

  always_comb begin
    res_valid = '0;
    res_data  = '0;
    for (int k = 0; k < NU; k++) begin
      if (res_en[k] && uwr[k] != urd[k]) begin
        res_valid[k]       = 1'b1;
        res_data[k*W +: W] = ures[k][urd[k] % 16];
      end
    end
  end

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
    logic          err;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input logic [SW-1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.sel  = sel;
    e.err  = (32'(sel) >= NU);
    e.data = e.err ? '0 : W'(a + b + W'(sel));
    sb.push_back(e);
  endtask

  // Transfers complete at the next rising edge; sample mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_sel", 32'(out_sel), 32'(e.sel));
        check("out_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_op1   = a;
    in_op2   = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (in_ready) begin
        push_exp(sel, a, b);
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_sel   = '0;
    in_op1   = '0;
    in_op2   = '0;
    if (!done) check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick(1);
    check(name, 32'(sb.size()), 32'(0));
  endtask

  typedef struct {
    logic [SW-1:0] sel;
    logic [W-1:0]  op1;
    logic [W-1:0]  op2;
    logic [NU-1:0] exp_uv;
  } vec_t;

  initial begin
    vec_t vecs [5];
    vecs[0] = '{2'd1, 17'h00A3C, 17'h00455, 3'b010};
    vecs[1] = '{2'd0, 17'h1FFFF, 17'h00001, 3'b001};
    vecs[2] = '{2'd2, 17'h10000, 17'h0FFFF, 3'b100};
    vecs[3] = '{2'd3, 17'h00ABC, 17'h00DEF, 3'b000};
    vecs[4] = '{2'd1, 17'h15555, 17'h0AAAA, 3'b010};

    reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_op1 = '0; in_op2 = '0;
    unit_ready = 3'b111; res_en = 3'b111; out_ready = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_unit_valid", 32'(unit_valid), 32'(0));
    check("rst_unit_op1", 32'(unit_op1[31:0]), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_res_ready", 32'(res_ready), 32'(0));

    // Table: one op at a time, all units ready.
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].sel, vecs[v].op1, vecs[v].op2);
      check("tbl_unit_valid", 32'(unit_valid), 32'(vecs[v].exp_uv));
      for (int k = 0; k < NU; k++) begin
        check("tbl_slice_op1", 32'(unit_op1[k*W +: W]), 32'(vecs[v].exp_uv[k] ? vecs[v].op1 : '0));
        check("tbl_slice_op2", 32'(unit_op2[k*W +: W]), 32'(vecs[v].exp_uv[k] ? vecs[v].op2 : '0));
      end
      if (vecs[v].exp_uv == '0) begin
        check("err_not_yet", 32'(out_valid), 32'(0));
        tick(1);
        check("err_out_valid", 32'(out_valid), 32'(1));
        check("err_out_err", 32'(out_err), 32'(1));
      end
      tick(3);
    end
    drain("tbl_drain");

    // Reordering: div issued first, add result ready early but must wait.
    res_en = 3'b000;
    send(2'd2, 17'h01000, 17'h00200);
    send(2'd0, 17'h00030, 17'h00004);
    tick(1);
    res_en = 3'b001;
    for (int i = 0; i < 3; i++) begin
      check("reord_res_ready", 32'(res_ready), 32'(3'b100));
      check("reord_out_valid", 32'(out_valid), 32'(0));
      tick(1);
    end
    res_en = 3'b101;
    drain("reord_drain");

    // Backpressure on unit 0.
    res_en = 3'b111;
    unit_ready = 3'b110;
    send(2'd0, 17'h00111, 17'h00222);
    in_valid = 1'b1; in_sel = 2'd0; in_op1 = 17'h00333; in_op2 = 17'h00444;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_unit_valid", 32'(unit_valid), 32'(3'b001));
      check("bp_hold_op1", 32'(unit_op1[0 +: W]), 32'(17'h00111));
      check("bp_hold_op2", 32'(unit_op2[0 +: W]), 32'(17'h00222));
      tick(1);
    end
    unit_ready = 3'b111;
    @(negedge clock);
    check("bp_release_ready", 32'(in_ready), 32'(1));
    if (in_ready) push_exp(2'd0, 17'h00333, 17'h00444);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("bp_second_valid", 32'(unit_valid), 32'(3'b001));
    check("bp_second_op1", 32'(unit_op1[0 +: W]), 32'(17'h00333));
    tick(1);
    check("bp_done_valid", 32'(unit_valid), 32'(0));
    drain("bp_drain");

    // Queue full: four outstanding on unit 1, fifth held until a pop.
    res_en = 3'b000;
    for (int i = 0; i < 5; i++) send(2'd1, 17'(i * 16), 17'(i + 1));
    for (int i = 0; i < 3; i++) begin
      check("full_unit_valid", 32'(unit_valid), 32'(0));
      check("full_in_ready", 32'(in_ready), 32'(0));
      tick(1);
    end
    res_en = 3'b010;
    tick(1);
    res_en = 3'b000;
    check("full_fifth_issue", 32'(unit_valid), 32'(3'b010));
    check("full_fifth_op1", 32'(unit_op1[W +: W]), 32'(17'd64));
    tick(1);
    check("full_after_issue", 32'(unit_valid), 32'(0));
    res_en = 3'b111;
    drain("full_drain");

    // Invalid select behind an outstanding op.
    res_en = 3'b000;
    send(2'd1, 17'h00050, 17'h00005);
    send(2'd3, 17'h01234, 17'h04321);
    check("inv_unit_valid", 32'(unit_valid), 32'(0));
    tick(1);
    check("inv_wait_head", 32'(out_valid), 32'(0));
    res_en = 3'b010;
    drain("inv_drain");

    // Reset mid-flight.
    res_en = 3'b000;
    send(2'd0, 17'h00001, 17'h00002);
    send(2'd1, 17'h00003, 17'h00004);
    send(2'd2, 17'h00005, 17'h00006);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sb.delete();
    check("mrst_out_valid", 32'(out_valid), 32'(0));
    check("mrst_in_ready", 32'(in_ready), 32'(1));
    check("mrst_res_ready", 32'(res_ready), 32'(0));
    check("mrst_unit_valid", 32'(unit_valid), 32'(0));
    res_en = 3'b111;
    send(2'd2, 17'h00777, 17'h00111);
    drain("mrst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
